// File: rtl/stream_align_pkg.sv
// Shared sizing helpers and types for the stream_align receive-side aligner.
// The skew monitor is built only when STREAM_ALIGN_SKEW_MON_EN is defined.
package stream_align_pkg;

    localparam int unsigned SA_DEPTH = 16;

    function automatic int unsigned ptr_w(input int unsigned depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

    localparam bit SA_DEPTH_POW2 = is_pow2(SA_DEPTH);

    // Occupancy of a default-depth buffer, 0..SA_DEPTH inclusive.
    typedef logic [ptr_w(SA_DEPTH):0] cnt_t;

endpackage

// File: rtl/align_fifo.sv
// Register-array FIFO holding one stream while it waits for its partner.
// Push on a full buffer is accepted only when a pop happens in the same cycle.
module align_fifo
    import stream_align_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = SA_DEPTH,
    parameter bit          POW2  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [WIDTH-1:0]        data_i,
    input  logic                    pop_i,
    output logic [WIDTH-1:0]        head_o,
    output logic [ptr_w(DEPTH):0]   count_o,
    output logic                    full_o
);

    localparam int unsigned PW = ptr_w(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (POW2) begin
            return p + 1'b1;
        end
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CW'(DEPTH));
    assign pop_ok  = pop_i && !flush_i && (count_q != '0);
    assign push_ok = push_i && !flush_i && (!full_o || pop_ok);

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
            if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is not reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/stream_align.sv
// Pairs two valid-tagged streams of differing latency into time-aligned A/B samples.
// Define STREAM_ALIGN_SKEW_MON_EN to register count_a - count_b on the skew output.
module stream_align
    import stream_align_pkg::*;
#(
    parameter int unsigned WIDTH_A = 32,
    parameter int unsigned WIDTH_B = 32,
    parameter int unsigned DEPTH   = SA_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          a_valid,
    input  logic [WIDTH_A-1:0]            a_data,
    input  logic                          b_valid,
    input  logic [WIDTH_B-1:0]            b_data,
    output logic                          out_valid,
    output logic [WIDTH_A-1:0]            out_a,
    output logic [WIDTH_B-1:0]            out_b,
    output logic                          ovf_a,
    output logic                          ovf_b,
    output logic signed [ptr_w(DEPTH)+1:0] skew
);

    localparam int unsigned CW         = ptr_w(DEPTH) + 1;
    localparam bit          DEPTH_POW2 = is_pow2(DEPTH);

    logic [CW-1:0]      count_a, count_b;
    logic               full_a, full_b;
    logic [WIDTH_A-1:0] head_a;
    logic [WIDTH_B-1:0] head_b;
    logic               pop, drop_a, drop_b;

    logic               out_valid_q, out_valid_d;
    logic [WIDTH_A-1:0] out_a_q, out_a_d;
    logic [WIDTH_B-1:0] out_b_q, out_b_d;
    logic               ovf_a_q, ovf_a_d;
    logic               ovf_b_q, ovf_b_d;

    // Pop decision looks only at registered counts, giving a two-cycle minimum latency.
    assign pop    = !flush && (count_a != '0) && (count_b != '0);
    assign drop_a = a_valid && full_a && !pop && !flush;
    assign drop_b = b_valid && full_b && !pop && !flush;

    align_fifo #(
        .WIDTH (WIDTH_A),
        .DEPTH (DEPTH),
        .POW2  (DEPTH_POW2)
    ) u_fifo_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (a_valid),
        .data_i  (a_data),
        .pop_i   (pop),
        .head_o  (head_a),
        .count_o (count_a),
        .full_o  (full_a)
    );

    align_fifo #(
        .WIDTH (WIDTH_B),
        .DEPTH (DEPTH),
        .POW2  (DEPTH_POW2)
    ) u_fifo_b (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .push_i  (b_valid),
        .data_i  (b_data),
        .pop_i   (pop),
        .head_o  (head_b),
        .count_o (count_b),
        .full_o  (full_b)
    );

    always_comb begin
        out_valid_d = pop;
        out_a_d     = pop ? head_a : out_a_q;
        out_b_d     = pop ? head_b : out_b_q;
        ovf_a_d     = flush ? 1'b0 : (ovf_a_q | drop_a);
        ovf_b_d     = flush ? 1'b0 : (ovf_b_q | drop_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_a_q     <= '0;
            out_b_q     <= '0;
            ovf_a_q     <= 1'b0;
            ovf_b_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_a_q     <= out_a_d;
            out_b_q     <= out_b_d;
            ovf_a_q     <= ovf_a_d;
            ovf_b_q     <= ovf_b_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;
    assign ovf_a     = ovf_a_q;
    assign ovf_b     = ovf_b_q;

`ifdef STREAM_ALIGN_SKEW_MON_EN
    logic signed [CW:0] skew_q, skew_d;

    always_comb begin
        skew_d = flush ? '0 : ($signed({1'b0, count_a}) - $signed({1'b0, count_b}));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skew_q <= '0;
        end else begin
            skew_q <= skew_d;
        end
    end

    assign skew = skew_q;
`else
    assign skew = '0;
`endif

endmodule

// File: tb/tb_stream_align.sv
// Directed self-checking bench for stream_align with DEPTH=16.
// Skew expectations follow STREAM_ALIGN_SKEW_MON_EN when it is defined.
module tb_stream_align;

    localparam int D  = 16;
    localparam int SW = $clog2(D) + 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 flush;
    logic                 a_valid, b_valid;
    logic [31:0]          a_data, b_data;
    logic                 out_valid;
    logic [31:0]          out_a, out_b;
    logic                 ovf_a, ovf_b;
    logic signed [SW-1:0] skew;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int skew_max;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    int          qc[$];

    stream_align #(.WIDTH_A(32), .WIDTH_B(32), .DEPTH(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .a_valid   (a_valid),
        .a_data    (a_data),
        .b_valid   (b_valid),
        .b_data    (b_data),
        .out_valid (out_valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .ovf_a     (ovf_a),
        .ovf_b     (ovf_b),
        .skew      (skew)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            qa.push_back(out_a);
            qb.push_back(out_b);
            qc.push_back(cyc);
        end
        if (int'(skew) > skew_max) skew_max = int'(skew);
    end

    task automatic step(input logic av, input logic [31:0] ad, input logic bv, input logic [31:0] bd);
        a_valid = av;
        a_data  = ad;
        b_valid = bv;
        b_data  = bd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic clear_q();
        qa.delete();
        qb.delete();
        qc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        a_valid = 1'b0; a_data = '0;
        b_valid = 1'b0; b_data = '0;
        skew_max = 0;
        #2;
        checks++;
        if ({out_valid, ovf_a, ovf_b} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got valid/ovf_a/ovf_b=%b%b%b want 000", out_valid, ovf_a, ovf_b);
        end
        checks++;
        if ({out_a, out_b, skew} !== '0) begin
            errors++;
            $display("FAIL reset_data got out_a=%h out_b=%h skew=%0d want 0", out_a, out_b, skew);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        int t0;
        clear_q();
        t0 = cyc;
        for (int k = 0; k < 8; k++) step(1'b1, 32'(k), 1'b1, 32'(k));
        idle(4);
        checks++;
        if (qa.size() != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d pairs want 8", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 8; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL b2b_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
        if (qc.size() > 0) begin
            checks++;
            if (qc[0] != t0 + 2) begin
                errors++;
                $display("FAIL b2b_latency got %0d want 2", qc[0] - t0);
            end
        end
    endtask

    task automatic test_b_delayed();
        int t0;
        clear_q();
        skew_max = 0;
        t0 = cyc;
        for (int i = 0; i < 15; i++) step(i < 10, 32'(i), i >= 5, 32'(i - 5));
        idle(8);
        checks++;
        if (qa.size() != 10) begin
            errors++;
            $display("FAIL delay_count got %0d pairs want 10", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 10; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL delay_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
        if (qc.size() > 0) begin
            checks++;
            if (qc[0] != t0 + 7) begin
                errors++;
                $display("FAIL delay_latency got %0d want 7", qc[0] - t0);
            end
        end
        checks++;
`ifdef STREAM_ALIGN_SKEW_MON_EN
        if (skew_max != 5) begin
            errors++;
            $display("FAIL delay_skew_peak got %0d want 5", skew_max);
        end
`else
        if (skew_max != 0) begin
            errors++;
            $display("FAIL delay_skew_peak got %0d want 0", skew_max);
        end
`endif
    endtask

    task automatic test_overflow();
        // Lead of exactly DEPTH: nothing dropped.
        clear_q();
        for (int k = 0; k < 16; k++) step(1'b1, 32'(k), 1'b0, 32'd0);
        for (int k = 0; k < 16; k++) step(1'b0, 32'd0, 1'b1, 32'(k));
        idle(4);
        checks++;
        if (qa.size() != 16 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL lead16 got %0d pairs ovf_a=%b want 16 pairs ovf_a=0", qa.size(), ovf_a);
        end
        for (int i = 0; i < qa.size() && i < 16; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL lead16_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
        // Lead of DEPTH+1: the 17th A is dropped and ovf_a latches.
        clear_q();
        for (int k = 0; k < 16; k++) step(1'b1, 32'(k), 1'b0, 32'd0);
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL lead17_pre_ovf got %b want 0", ovf_a);
        end
        step(1'b1, 32'd16, 1'b0, 32'd0);
        checks++;
        if (ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL lead17_ovf_set got %b want 1", ovf_a);
        end
        for (int k = 0; k < 17; k++) step(1'b0, 32'd0, 1'b1, 32'(k));
        idle(3);
        step(1'b1, 32'd100, 1'b0, 32'd0);
        idle(3);
        checks++;
        if (qa.size() != 17) begin
            errors++;
            $display("FAIL lead17_count got %0d pairs want 17", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 16; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL lead17_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
        if (qa.size() == 17) begin
            checks++;
            if (qa[16] !== 32'd100 || qb[16] !== 32'd16) begin
                errors++;
                $display("FAIL lead17_misaligned got (%0d,%0d) want (100,16)", qa[16], qb[16]);
            end
        end
        checks++;
        if (ovf_a !== 1'b1 || ovf_b !== 1'b0) begin
            errors++;
            $display("FAIL lead17_sticky got ovf_a=%b ovf_b=%b want 1 0", ovf_a, ovf_b);
        end
    endtask

    task automatic test_flush();
        clear_q();
        for (int k = 0; k < 4; k++) step(1'b1, 32'(90 + k), 1'b0, 32'd0);
        checks++;
        if (ovf_a !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre_ovf got %b want 1", ovf_a);
        end
        flush = 1'b1;
        step(1'b1, 32'd77, 1'b1, 32'd77);
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear got out_valid=%b ovf_a=%b want 0 0", out_valid, ovf_a);
        end
        for (int k = 0; k < 3; k++) step(1'b1, 32'(k), 1'b1, 32'(k));
        idle(5);
        checks++;
        if (qa.size() != 3) begin
            errors++;
            $display("FAIL flush_count got %0d pairs want 3", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 3; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL flush_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
    endtask

    task automatic test_full_push_pop();
        clear_q();
        for (int k = 0; k < 16; k++) step(1'b1, 32'(k), 1'b0, 32'd0);
        step(1'b0, 32'd0, 1'b1, 32'd0);
        step(1'b1, 32'd16, 1'b0, 32'd0);
        checks++;
        if (ovf_a !== 1'b0) begin
            errors++;
            $display("FAIL fullpp_ovf got %b want 0", ovf_a);
        end
        for (int k = 1; k <= 16; k++) step(1'b0, 32'd0, 1'b1, 32'(k));
        idle(4);
        checks++;
        if (qa.size() != 17) begin
            errors++;
            $display("FAIL fullpp_count got %0d pairs want 17", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 17; i++) begin
            checks++;
            if (qa[i] !== 32'(i) || qb[i] !== 32'(i)) begin
                errors++;
                $display("FAIL fullpp_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], i, i);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t0;
        for (int k = 0; k < 5; k++) step(1'b1, 32'(k), 1'b1, 32'(k));
        rst_n = 1'b0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        #1;
        checks++;
        if ({out_valid, ovf_a, ovf_b} !== 3'b000 || {out_a, out_b, skew} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got v=%b a=%h b=%h ovf=%b%b skew=%0d want all 0",
                     out_valid, out_a, out_b, ovf_a, ovf_b, skew);
        end
        clear_q();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(6);
        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("FAIL midreset_leftover got %0d pairs want 0", qa.size());
        end
        clear_q();
        t0 = cyc;
        for (int k = 0; k < 3; k++) step(1'b1, 32'(50 + k), 1'b1, 32'(50 + k));
        idle(4);
        checks++;
        if (qa.size() != 3) begin
            errors++;
            $display("FAIL midreset_count got %0d pairs want 3", qa.size());
        end
        for (int i = 0; i < qa.size() && i < 3; i++) begin
            checks++;
            if (qa[i] !== 32'(50 + i) || qb[i] !== 32'(50 + i)) begin
                errors++;
                $display("FAIL midreset_pair%0d got (%0d,%0d) want (%0d,%0d)", i, qa[i], qb[i], 50 + i, 50 + i);
            end
        end
        if (qc.size() > 0) begin
            checks++;
            if (qc[0] != t0 + 2) begin
                errors++;
                $display("FAIL midreset_latency got %0d want 2", qc[0] - t0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_b_delayed();
        test_overflow();
        test_flush();
        test_full_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
